// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for the multi-cycle Light RV32I core. Walks each instruction
// through FETCH, DECODE, EXEC, MEM and WB and drives the ALU, register file,
// PC/IR registers and the unified memory port.
// Supported subset: R-type, I-type ALU, LW, SW, BEQ/BLT, JAL, LUI.
// Optional feature macro: LIGHT_MC_MEM_WAIT_EN. When defined, FETCH and MEM
// stall until i_MemReady. When undefined, every memory access takes one cycle.
// All outputs are combinational from the state and the instruction, and they
// are forced to their idle values while i_Rst_n is low.

`ifndef _INST_WIDTH_
`define _INST_WIDTH_ 32
`endif

module multicycle_controller #(
    parameter int unsigned INST_WIDTH  = `_INST_WIDTH_,
    parameter logic [2:0]  RESET_STATE = 3'd0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [INST_WIDTH-1:0] i_Instruction,
    input  logic                  i_Zero,
    input  logic                  i_Less,
    input  logic                  i_MemReady,
    output logic                  o_PcWrEn,
    output logic                  o_PcSrc,
    output logic                  o_IrWrEn,
    output logic                  o_MemRdEn,
    output logic                  o_MemWrEn,
    output logic                  o_MemAddrSel,
    output logic                  o_RegWrEn,
    output logic [1:0]            o_WbSel,
    output logic [2:0]            o_ExtOp,
    output logic                  o_Alu1Src,
    output logic [1:0]            o_Alu2Src,
    output logic [3:0]            o_AluCtr,
    output logic                  o_Illegal,
    output logic                  o_Retire
);

    // Opcode field values
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // ALU operation codes; the logic/shift group is {0, func3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRCB = 4'b1111;

    // Immediate extender selects
    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_S = 3'd1;
    localparam logic [2:0] EXT_B = 3'd2;
    localparam logic [2:0] EXT_U = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    // ALU operand B selects
    localparam logic [1:0] SRC2_RS2  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;

    // Write-back selects
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_rtype;
    logic       is_itype;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_lui;
    logic       is_illegal;
    logic       branch_taken;
    logic       mem_done;
    logic [2:0] ext_sel;
    logic [3:0] rtype_alu;
    logic       unused_bits;

    assign opcode = i_Instruction[6:0];
    assign funct3 = i_Instruction[14:12];
    assign funct7 = i_Instruction[31:25];

    // Register fields and any bits above 31 are consumed by the datapath only
    assign unused_bits = ^{i_Instruction, i_MemReady};

    assign is_rtype   = (opcode == OP_RTYPE);
    assign is_itype   = (opcode == OP_ITYPE);
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign is_branch  = (opcode == OP_BRNCH);
    assign is_jal     = (opcode == OP_JAL);
    assign is_lui     = (opcode == OP_LUI);
    assign is_illegal = !(is_rtype | is_itype | is_load | is_store |
                          is_branch | is_jal | is_lui);

    // BEQ uses the zero flag; any other branch func3 is treated as BLT
    assign branch_taken = (funct3 == 3'b000) ? i_Zero : i_Less;

`ifdef LIGHT_MC_MEM_WAIT_EN
    assign mem_done = i_MemReady;
`else
    assign mem_done = 1'b1;
`endif

    // Immediate format chosen from the opcode
    always_comb begin
        ext_sel = EXT_I;
        if (is_store)  ext_sel = EXT_S;
        if (is_branch) ext_sel = EXT_B;
        if (is_lui)    ext_sel = EXT_U;
        if (is_jal)    ext_sel = EXT_J;
    end

    // R-type ALU op: plain group passes func3 through, 0x20 selects SUB
    always_comb begin
        rtype_alu = ALU_ADD;
        if (funct7 == 7'h00) begin
            rtype_alu = {1'b0, funct3};
        end else if (funct7 == 7'h20) begin
            rtype_alu = ALU_SUB;
        end
    end

    // State sequencing; unused encodings recover to FETCH
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_done) state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= is_illegal ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    if (is_branch)                 state <= S_FETCH;
                    else if (is_load || is_store)  state <= S_MEM;
                    else                           state <= S_WB;
                end
                S_MEM: begin
                    if (mem_done) state <= is_load ? S_WB : S_FETCH;
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Control outputs decoded from the current state and instruction
    always_comb begin
        o_PcWrEn     = 1'b0;
        o_PcSrc      = 1'b0;
        o_IrWrEn     = 1'b0;
        o_MemRdEn    = 1'b0;
        o_MemWrEn    = 1'b0;
        o_MemAddrSel = 1'b0;
        o_RegWrEn    = 1'b0;
        o_WbSel      = WB_ALU;
        o_ExtOp      = EXT_I;
        o_Alu1Src    = 1'b0;
        o_Alu2Src    = SRC2_RS2;
        o_AluCtr     = ALU_ADD;
        o_Illegal    = 1'b0;
        o_Retire     = 1'b0;

        if (i_Rst_n) begin
            case (state)
                S_FETCH: begin
                    // PC+4 is formed through the OldPC operand path
                    o_MemRdEn = 1'b1;
                    o_IrWrEn  = mem_done;
                    o_PcWrEn  = mem_done;
                    o_Alu1Src = 1'b1;
                    o_Alu2Src = SRC2_FOUR;
                end
                S_DECODE: begin
                    o_ExtOp = ext_sel;
                    if (is_illegal) begin
                        o_Illegal = 1'b1;
                        o_Retire  = 1'b1;
                    end
                end
                S_EXEC: begin
                    o_ExtOp = ext_sel;
                    if (is_rtype) begin
                        o_Alu2Src = SRC2_RS2;
                        o_AluCtr  = rtype_alu;
                    end else if (is_itype || is_load || is_store) begin
                        o_Alu2Src = SRC2_IMM;
                    end else if (is_lui) begin
                        o_Alu2Src = SRC2_IMM;
                        o_AluCtr  = ALU_SRCB;
                    end else if (is_branch) begin
                        // Target comes from the dedicated OldPC+imm adder
                        o_Alu2Src = SRC2_RS2;
                        o_AluCtr  = (funct3 == 3'b000) ? ALU_SUB : ALU_SLT;
                        o_PcWrEn  = branch_taken;
                        o_PcSrc   = branch_taken;
                        o_Retire  = 1'b1;
                    end else if (is_jal) begin
                        o_Alu1Src = 1'b1;
                        o_Alu2Src = SRC2_IMM;
                        o_PcWrEn  = 1'b1;
                        o_PcSrc   = 1'b1;
                    end
                end
                S_MEM: begin
                    o_ExtOp      = ext_sel;
                    o_MemAddrSel = 1'b1;
                    if (is_load) begin
                        o_MemRdEn = 1'b1;
                    end else begin
                        o_MemWrEn = 1'b1;
                        o_Retire  = mem_done;
                    end
                end
                S_WB: begin
                    o_ExtOp   = ext_sel;
                    o_RegWrEn = 1'b1;
                    o_Retire  = 1'b1;
                    if (is_load)     o_WbSel = WB_MEM;
                    else if (is_jal) o_WbSel = WB_PC;
                    else             o_WbSel = WB_ALU;
                end
                default: begin
                    o_AluCtr = ALU_ADD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. A plan of per-cycle inputs and
// expected outputs is built from each instruction's stage list (the latency
// table); the driver issues one cycle at a time and pushes the expectation,
// and an independent monitor pops and compares on the falling edge.
`timescale 1ns/1ps

module tb_multicycle_controller;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

`ifdef LIGHT_MC_MEM_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    typedef struct packed {
        logic       pc_wr;
        logic       pc_src;
        logic       ir_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_addr;
        logic       reg_wr;
        logic [1:0] wb_sel;
        logic [2:0] ext;
        logic       alu1;
        logic [1:0] alu2;
        logic [3:0] alu;
        logic       ill;
        logic       ret;
    } outs_t;

    typedef struct packed {
        logic        rst_n;
        logic [31:0] instr;
        logic        zero;
        logic        less;
        logic        rdy;
    } ins_t;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n;
    logic [31:0] i_Instruction = '0;
    logic        i_Zero = 1'b0;
    logic        i_Less = 1'b0;
    logic        i_MemReady = 1'b0;
    logic        o_PcWrEn, o_PcSrc, o_IrWrEn, o_MemRdEn, o_MemWrEn;
    logic        o_MemAddrSel, o_RegWrEn, o_Alu1Src, o_Illegal, o_Retire;
    logic [1:0]  o_WbSel, o_Alu2Src;
    logic [2:0]  o_ExtOp;
    logic [3:0]  o_AluCtr;
    outs_t       act;

    always #5 i_Clk = ~i_Clk;

    multicycle_controller #(.INST_WIDTH(32), .RESET_STATE(3'd0)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Instruction(i_Instruction),
        .i_Zero       (i_Zero),
        .i_Less       (i_Less),
        .i_MemReady   (i_MemReady),
        .o_PcWrEn     (o_PcWrEn),
        .o_PcSrc      (o_PcSrc),
        .o_IrWrEn     (o_IrWrEn),
        .o_MemRdEn    (o_MemRdEn),
        .o_MemWrEn    (o_MemWrEn),
        .o_MemAddrSel (o_MemAddrSel),
        .o_RegWrEn    (o_RegWrEn),
        .o_WbSel      (o_WbSel),
        .o_ExtOp      (o_ExtOp),
        .o_Alu1Src    (o_Alu1Src),
        .o_Alu2Src    (o_Alu2Src),
        .o_AluCtr     (o_AluCtr),
        .o_Illegal    (o_Illegal),
        .o_Retire     (o_Retire)
    );

    assign act = {o_PcWrEn, o_PcSrc, o_IrWrEn, o_MemRdEn, o_MemWrEn, o_MemAddrSel,
                  o_RegWrEn, o_WbSel, o_ExtOp, o_Alu1Src, o_Alu2Src, o_AluCtr,
                  o_Illegal, o_Retire};

    // Plan (stimulus not yet issued) and scoreboard (issued, awaiting check)
    ins_t        pin[$];
    outs_t       pout[$];
    string       ptag[$];
    outs_t       exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    int          retire_exp = 0;
    int          retire_seen = 0;
    logic [31:0] last_instr = '0;
    bit          force_nowait = 1'b0;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI};
    endfunction

    function automatic logic [2:0] ext_of(input logic [6:0] op);
        case (op)
            OP_SW:   return 3'd1;
            OP_BR:   return 3'd2;
            OP_LUI:  return 3'd3;
            OP_JAL:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int unsigned wait_cycles();
        if (WAIT_MODE && !force_nowait) return $urandom_range(0, 2);
        return 0;
    endfunction

    function automatic logic ready_bit(input bit done);
        logic r;
        r = 1'($urandom);
        return WAIT_MODE ? done : r;
    endfunction

    function automatic ins_t mk_in(input logic [31:0] ins, input logic z,
                                   input logic l, input logic r);
        ins_t c;
        c = '{rst_n: 1'b1, instr: ins, zero: z, less: l, rdy: r};
        return c;
    endfunction

    task automatic add(input ins_t i, input outs_t o, input string t);
        pin.push_back(i);
        pout.push_back(o);
        ptag.push_back(t);
    endtask

    task automatic add_reset(input int unsigned n);
        ins_t c;
        for (int unsigned k = 0; k < n; k++) begin
            c = mk_in($urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            c.rst_n = 1'b0;
            add(c, '0, "reset");
        end
    endtask

    // Reference model: one entry per cycle from the instruction's stage list
    task automatic gen_instr(input logic [31:0] ins, input logic z, input logic l);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        string       st;
        byte         ch;
        int unsigned nw;
        bit          done, last;
        outs_t       o;
        logic [31:0] cur_in;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (op)
            OP_R, OP_I, OP_LUI, OP_JAL: st = "FDXW";
            OP_LW:                      st = "FDXMW";
            OP_SW:                      st = "FDXM";
            OP_BR:                      st = "FDX";
            default:                    st = "FD";
        endcase
        for (int s = 0; s < st.len(); s++) begin
            ch   = st[s];
            last = (s == st.len() - 1);
            nw   = (ch == "F" || ch == "M") ? wait_cycles() : 0;
            for (int unsigned k = 0; k <= nw; k++) begin
                done   = (k == nw);
                o      = '0;
                cur_in = (ch == "F") ? last_instr : ins;
                if (ch != "F") o.ext = ext_of(op);
                o.ret = last && done;
                case (ch)
                    "F": begin
                        o.mem_rd = 1'b1;
                        o.alu1   = 1'b1;
                        o.alu2   = 2'd2;
                        o.pc_wr  = done;
                        o.ir_wr  = done;
                    end
                    "D": o.ill = !is_legal(op);
                    "X": begin
                        if (op == OP_R) begin
                            if (f7 == 7'h00)      o.alu = {1'b0, f3};
                            else if (f7 == 7'h20) o.alu = 4'b1000;
                        end else if (op == OP_LUI) begin
                            o.alu2 = 2'd1;
                            o.alu  = 4'b1111;
                        end else if (op == OP_BR) begin
                            o.alu    = (f3 == 3'b000) ? 4'b1000 : 4'b0010;
                            o.pc_wr  = (f3 == 3'b000) ? z : l;
                            o.pc_src = o.pc_wr;
                        end else if (op == OP_JAL) begin
                            o.alu1   = 1'b1;
                            o.alu2   = 2'd1;
                            o.pc_wr  = 1'b1;
                            o.pc_src = 1'b1;
                        end else begin
                            o.alu2 = 2'd1;
                        end
                    end
                    "M": begin
                        o.mem_addr = 1'b1;
                        o.mem_rd   = (op == OP_LW);
                        o.mem_wr   = (op == OP_SW);
                    end
                    default: begin
                        o.reg_wr = 1'b1;
                        o.wb_sel = (op == OP_LW) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
                    end
                endcase
                add(mk_in(cur_in, z, l,
                          (ch == "F" || ch == "M") ? ready_bit(done) : 1'($urandom)),
                    o, $sformatf("%08h/%c%0d", ins, ch, k));
            end
        end
        last_instr = ins;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: begin
                r[6:0] = OP_R;
                case ($urandom_range(0, 2))
                    0:       r[31:25] = 7'h00;
                    1:       r[31:25] = 7'h20;
                    default: r[31:25] = 7'($urandom);
                endcase
            end
            1: r[6:0] = OP_I;
            2: r[6:0] = OP_LW;
            3: r[6:0] = OP_SW;
            4: r[6:0] = OP_BR;
            5: r[6:0] = OP_JAL;
            6: r[6:0] = OP_LUI;
            default: begin
                while (is_legal(r[6:0])) r[6:0] = 7'($urandom);
            end
        endcase
        return r;
    endfunction

    // Monitor: compare every issued expectation one half-cycle later
    initial begin
        outs_t e;
        string t;
        forever begin
            @(negedge i_Clk);
            if (o_Retire === 1'b1) retire_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s got=%07h (pcw pcs irw rd wr as rw wb ext a1 a2 alu ill ret = %b %b %b %b %b %b %b %0d %0d %b %0d %h %b %b) exp=%07h",
                             t, act, act.pc_wr, act.pc_src, act.ir_wr, act.mem_rd, act.mem_wr,
                             act.mem_addr, act.reg_wr, act.wb_sel, act.ext, act.alu1,
                             act.alu2, act.alu, act.ill, act.ret, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    // Stimulus: build the plan, then issue it cycle by cycle
    initial begin
        ins_t c;
        int   n;
        i_Rst_n = 1'b0;

        add_reset(3);
        gen_instr(32'h002081B3, 1'b0, 1'b0);
        gen_instr(32'h00402283, 1'b1, 1'b1);
        gen_instr(32'h00502423, 1'b0, 1'b1);
        gen_instr(32'h00208463, 1'b1, 1'b0);
        gen_instr(32'h00208463, 1'b0, 1'b1);
        gen_instr(32'h00000000, 1'b1, 1'b1);
        gen_instr(32'h0000006F, 1'b0, 1'b0);
        gen_instr(32'h123450B7, 1'b0, 1'b0);
        gen_instr(32'h0020C463, 1'b1, 1'b1);

        // Abort a load after EXEC: no MEM/WB may follow the reset
        force_nowait = 1'b1;
        n = pin.size();
        gen_instr(32'h00402283, 1'b0, 1'b0);
        while (pin.size() > n + 3) begin
            void'(pin.pop_back());
            void'(pout.pop_back());
            void'(ptag.pop_back());
        end
        force_nowait = 1'b0;
        add_reset(2);

        for (int i = 0; i < 70; i++) begin
            gen_instr(rand_instr(), 1'($urandom), 1'($urandom));
        end

        @(posedge i_Clk);
        #1;
        while (pin.size() > 0) begin
            c             = pin.pop_front();
            i_Rst_n       = c.rst_n;
            i_Instruction = c.instr;
            i_Zero        = c.zero;
            i_Less        = c.less;
            i_MemReady    = c.rdy;
            exp_q.push_back(pout[0]);
            tag_q.push_back(ptag.pop_front());
            if (pout[0].ret) retire_exp++;
            void'(pout.pop_front());
            @(posedge i_Clk);
            #1;
        end

        @(negedge i_Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        checks++;
        if (retire_seen != retire_exp) begin
            errors++;
            $display("FAIL retire_count got=%0d exp=%0d", retire_seen, retire_exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
